// File: rtl/tile_blitter.sv
// tile_blitter: rasterises one 4x4 tile sprite into the 160x120x3 frame buffer.
// One request draws one map cell, one pixel per clock, then pulses done.
// Optional build macro BLIT_CLEAR_EN adds clr_start and a full-buffer clear.
module tile_blitter #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned TILE   = 4,
  parameter int unsigned MAP_W  = 40,
  parameter int unsigned MAP_H  = 30,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_x,
  input  logic [4:0]        req_y,
  input  logic [3:0]        req_code,
`ifdef BLIT_CLEAR_EN
  input  logic              clr_start,
`endif
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              done,
  output logic              err
);

  // Map rows never exceed what the frame buffer can hold.
  localparam int unsigned ROWS = (MAP_H * TILE <= FB_H) ? MAP_H : FB_H / TILE;
  localparam logic [5:0] XLim = 6'(MAP_W);
  localparam logic [4:0] YLim = 5'(ROWS);
  localparam logic [3:0] PixLast = 4'(TILE * TILE - 1);
`ifdef BLIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] FbLast = ADDR_W'(FB_W * FB_H - 1);
`endif

  typedef enum logic [1:0] {StIdle, StDraw, StDone, StClear} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  x_q;
  logic [4:0]  y_q;
  logic [3:0]  code_q;
`ifdef BLIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  logic        clr_go;
  logic        handshake;
  logic        out_of_range;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        data_d;
  logic              done_d;
  logic              err_d;
  logic              ready_d;

  logic [5:0]        sel_x;
  logic [4:0]        sel_y;
  logic [3:0]        sel_code;
  logic [1:0]        pix_r;
  logic [1:0]        pix_c;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] tile_addr;

  // Colour of pixel (r,c) of the sprite for a tile code.
  function automatic logic [2:0] sprite(input logic [3:0] code, input logic [1:0] r,
                                        input logic [1:0] c);
    logic corner, inner, top_corner, eye;
    logic [2:0] body;
    corner     = (r == 2'd0 || r == 2'd3) && (c == 2'd0 || c == 2'd3);
    inner      = (r == 2'd1 || r == 2'd2) && (c == 2'd1 || c == 2'd2);
    top_corner = (r == 2'd0) && (c == 2'd0 || c == 2'd3);
    eye        = (r == 2'd1) && (c == 2'd1 || c == 2'd2);
    unique case (code)
      4'd5:    body = 3'b100;
      4'd6:    body = 3'b011;
      4'd7:    body = 3'b101;
      default: body = 3'b010;
    endcase
    unique case (code)
      4'd1:                   sprite = 3'b001;
      4'd2:                   sprite = inner ? 3'b111 : 3'b000;
      4'd3:                   sprite = corner ? 3'b000 : 3'b111;
      4'd4:                   sprite = corner ? 3'b000 : 3'b110;
      4'd5, 4'd6, 4'd7, 4'd8: sprite = top_corner ? 3'b000 : (eye ? 3'b111 : body);
      default:                sprite = 3'b000;
    endcase
  endfunction

`ifdef BLIT_CLEAR_EN
  assign clr_go = clr_start && (state_q == StIdle);
`else
  assign clr_go = 1'b0;
`endif
  // A clear request in IDLE pre-empts a tile request in the same cycle.
  assign handshake    = req_valid && req_ready && !clr_go;
  assign out_of_range = (req_x >= XLim) || (req_y >= YLim);

  // State, pixel counter and latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      code_q  <= '0;
`ifdef BLIT_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef BLIT_CLEAR_EN
      clr_q   <= clr_d;
`endif
      if (handshake) begin
        x_q    <= req_x;
        y_q    <= req_y;
        code_q <= req_code;
      end
    end
  end

  // Next-state and counter advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BLIT_CLEAR_EN
    clr_d   = clr_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef BLIT_CLEAR_EN
        if (clr_go) begin
          state_d = StClear;
          clr_d   = '0;
        end else
`endif
        if (handshake) begin
          cnt_d   = '0;
          state_d = out_of_range ? StDone : StDraw;
        end
      end
      StDraw: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == PixLast) state_d = StDone;
      end
      StDone: state_d = StIdle;
`ifdef BLIT_CLEAR_EN
      StClear: begin
        clr_d = clr_q + ADDR_W'(1);
        if (clr_q == FbLast) state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; on the accept edge the live request is used.
  always_comb begin
    sel_x     = handshake ? req_x : x_q;
    sel_y     = handshake ? req_y : y_q;
    sel_code  = handshake ? req_code : code_q;
    pix_r     = cnt_d[3:2];
    pix_c     = cnt_d[1:0];
    row_a     = ADDR_W'({sel_y, 2'b00}) + ADDR_W'(pix_r);
    tile_addr = row_a * ADDR_W'(FB_W) + ADDR_W'({sel_x, 2'b00}) + ADDR_W'(pix_c);

    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = 3'b000;
    if (state_d == StDraw) begin
      we_d   = 1'b1;
      addr_d = tile_addr;
      data_d = sprite(sel_code, pix_r, pix_c);
    end
`ifdef BLIT_CLEAR_EN
    if (state_d == StClear) begin
      we_d   = 1'b1;
      addr_d = clr_d;
    end
`endif
    done_d  = (state_d == StDone);
    // Only a rejected request goes straight from IDLE to DONE.
    err_d   = done_d && (state_q == StIdle);
    ready_d = (state_d == StIdle);
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= 3'b000;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      fb_we     <= we_d;
      fb_addr   <= addr_d;
      fb_data   <= data_d;
      done      <= done_d;
      err       <= err_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: expected frame-buffer writes are queued at each accept and
// popped by a monitor as the DUT writes them.
module tb_tile_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_x = '0;
  logic [4:0]  req_y = '0;
  logic [3:0]  req_code = '0;
`ifdef BLIT_CLEAR_EN
  logic        clr_start = 1'b0;
`endif
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        done;
  logic        err;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  logic [17:0] exp_q[$];

  tile_blitter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_code  (req_code),
`ifdef BLIT_CLEAR_EN
    .clr_start (clr_start),
`endif
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3 ms");
    $fatal(1);
  end

  // Reference sprite, written from the pixel table.
  function automatic logic [2:0] model_pix(input int code, input int r, input int c);
    logic [2:0] body;
    case (code)
      5: body = 3'b100;
      6: body = 3'b011;
      7: body = 3'b101;
      default: body = 3'b010;
    endcase
    case (code)
      1: return 3'b001;
      2: return ((r == 1 || r == 2) && (c == 1 || c == 2)) ? 3'b111 : 3'b000;
      3: return ((r == 0 || r == 3) && (c == 0 || c == 3)) ? 3'b000 : 3'b111;
      4: return ((r == 0 || r == 3) && (c == 0 || c == 3)) ? 3'b000 : 3'b110;
      5, 6, 7, 8: begin
        if (r == 0 && (c == 0 || c == 3)) return 3'b000;
        if (r == 1 && (c == 1 || c == 2)) return 3'b111;
        return body;
      end
      default: return 3'b000;
    endcase
  endfunction

  function automatic void push_tile(input int x, input int y, input int code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({15'((4 * y + r) * 160 + 4 * x + c), model_pix(code, r, c)});
  endfunction

  // Write monitor: every DUT write must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset && fb_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: addr=%0d data=%b, required no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        if ({fb_addr, fb_data} !== e) begin
          failed++;
          $display("FAIL fb_write: addr=%0d data=%b, required addr=%0d data=%b",
                   fb_addr, fb_data, e[17:3], e[2:0]);
        end
      end
    end
  end

  // Present a request and wait (bounded) for the accepting edge; returns at edge + 1.
  task automatic accept(input int x, input int y, input int code, input bit keep,
                        input int bound, output int acc, output bit ok);
    req_x = 6'(x);
    req_y = 5'(y);
    req_code = 4'(code);
    req_valid = 1'b1;
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < bound; i++) begin
      if (req_ready === 1'b1) begin
        if (x < 40 && y < 30) push_tile(x, y, code);
        @(posedge clk);
        #1;
        acc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!keep) req_valid = 1'b0;
    // Inputs wander after the handshake; the tile in progress must not care.
    req_x = 6'($urandom);
    req_y = 5'($urandom);
    req_code = 4'($urandom);
  endtask

  task automatic wait_done(input int bound, output bit got, output int at, output bit e);
    got = 1'b0;
    at = 0;
    e = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        at = cyc;
        e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if ({req_ready, fb_we, fb_addr, fb_data, done, err} !== 21'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %b, required all 0",
               {req_ready, fb_we, fb_addr, fb_data, done, err});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      failed++;
      $display("FAIL ready_before_edge: got %b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL ready_after_edge: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_tile(input string name, input int x, input int y, input int code);
    int acc, at;
    bit ok, got, e;
    accept(x, y, code, 1'b0, 64, acc, ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL %s_accept: not accepted, required accept within 64 cycles", name);
      return;
    end
    tests_run++;
    if (fb_we !== 1'b1) begin
      failed++;
      $display("FAIL %s_first_write: fb_we=%b after accept, required 1", name, fb_we);
    end
    wait_done(40, got, at, e);
    tests_run++;
    if (!got || at - acc != 16 || e !== 1'b0) begin
      failed++;
      $display("FAIL %s_done: got=%0d delay=%0d err=%b, required done 16 edges after accept, err 0",
               name, got, at - acc, e);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_end: done=%b left=%0d, required done 0 and 0 writes left",
               name, done, exp_q.size());
    end
  endtask

  task automatic test_out_of_range(input int x, input int y);
    int acc, at;
    bit ok, got, e;
    accept(x, y, 1, 1'b0, 64, acc, ok);
    wait_done(10, got, at, e);
    tests_run++;
    if (!ok || !got || at != acc || e !== 1'b1) begin
      failed++;
      $display("FAIL oor_%0d_%0d: ok=%0d done=%0d delay=%0d err=%b, required done+err right after accept",
               x, y, ok, got, at - acc, e);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || err !== 1'b0) begin
      failed++;
      $display("FAIL oor_pulse_width: done=%b err=%b, required 0 0", done, err);
    end
  endtask

  task automatic test_sprites();
    for (int code = 0; code < 16; code++)
      test_tile("sprite", int'($urandom_range(0, 39)), int'($urandom_range(0, 29)), code);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, at;
    bit ok1, ok2, got, e;
    accept(7, 11, 5, 1'b1, 64, acc1, ok1);
    accept(8, 11, 6, 1'b0, 64, acc2, ok2);
    tests_run++;
    if (!ok1 || !ok2 || acc2 - acc1 != 18) begin
      failed++;
      $display("FAIL back_to_back_gap: ok=%0d%0d gap=%0d, required 18", ok1, ok2, acc2 - acc1);
    end
    wait_done(40, got, at, e);
    @(negedge clk);
    tests_run++;
    if (!got || exp_q.size() != 0) begin
      failed++;
      $display("FAIL back_to_back_done: got=%0d left=%0d, required done and 0 left", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_blit();
    int acc;
    bit ok, seen;
    accept(10, 7, 4, 1'b0, 64, acc, ok);
    repeat (5) @(negedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 11) begin
      failed++;
      $display("FAIL mid_blit_progress: left=%0d, required 11", exp_q.size());
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (fb_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
      failed++;
      $display("FAIL mid_blit_reset: we=%b done=%b ready=%b, required 0 0 0", fb_we, done, req_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen || req_ready !== 1'b1) begin
      failed++;
      $display("FAIL mid_blit_no_done: done_seen=%0d ready=%b, required 0 and 1", seen, req_ready);
    end
  endtask

`ifdef BLIT_CLEAR_EN
  task automatic test_clear();
    int s, at, acc;
    bit got, e, ok;
    @(posedge clk);
    #1;
    req_x = 6'd2;
    req_y = 5'd2;
    req_code = 4'd5;
    req_valid = 1'b1;
    clr_start = 1'b1;
    for (int i = 0; i < 19200; i++) exp_q.push_back({15'(i), 3'b000});
    @(posedge clk);
    #1;
    s = cyc;
    clr_start = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0) begin
      failed++;
      $display("FAIL clear_priority: ready=%b, required 0", req_ready);
    end
    wait_done(20000, got, at, e);
    tests_run++;
    if (!got || at - s != 19200 || e !== 1'b0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL clear_done: got=%0d delay=%0d err=%b left=%0d, required 19200 0 0",
               got, at - s, e, exp_q.size());
    end
    accept(2, 2, 5, 1'b0, 8, acc, ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL clear_pending_req: not accepted, required accept after clear");
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL clear_pending_tile: left=%0d, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tile("wall", 0, 0, 1);
    test_tile("pellet", 39, 29, 2);
    test_out_of_range(40, 0);
    test_out_of_range(0, 30);
    test_sprites();
    test_back_to_back();
    test_reset_mid_blit();
`ifdef BLIT_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
